fetch_queue_stage: RTL and testbench
====================================

// Module: fetch_queue_stage
// PURPOSE
//  Parametrised fetch front-end for the five-stage pipeline; replaces fixed fetch + IF/ID register pair.
//  Generates PC, issues in-order instruction-memory requests (valid/ready), buffers returns in DEPTH-entry
//  prefetch queue, presents {pc,instr} to decode via valid/ready. Redirect (branch/flush) discards stale work.
// PARAMETERS
//  XLEN      32        PC / address width
//  ILEN      32        instruction width
//  DEPTH     4         queue entries; power of two, >=2; also max in-flight + buffered instructions
//  RESET_PC  32'h0     first fetch address after reset (XLEN bits)
//  PC_STEP   4         sequential PC increment
// PORTS
//  clk             in   1     clock, all state updates on rising edge
//  rst_n           in   1     synchronous active-low reset
//  redirect_valid  in   1     branch taken / flush from decode/execute
//  redirect_pc     in   XLEN  new fetch address
//  imem_req_valid  out  1     request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  request address (= PC register)
//  imem_rsp_valid  in   1     response valid; in order, always accepted
//  imem_rsp_data   in   ILEN  instruction word
//  id_valid        out  1     queue head valid toward decode
//  id_ready        in   1     decode accepts (low = stall, replaces IFIDWrite)
//  id_pc           out  XLEN  PC of head instruction
//  id_instr        out  ILEN  head instruction
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state=BOOT;
//   imem_req_valid=0, id_valid=0, id_pc/id_instr=0. Reset mid-operation discards everything, same values.
//  FSM: BOOT -> RUN after one cycle (no request in BOOT).
//   RUN  -> DRAIN on redirect_valid when outstanding minus same-cycle response > 0; else stays RUN.
//   DRAIN-> RUN the cycle drop_cnt reaches 0 (last stale response absorbed). Redirect in DRAIN reloads pc,
//           keeps DRAIN; drop_cnt keeps counting down, plus any requests accepted that cycle.
//  Issue: imem_req_valid = (state==RUN) && !redirect_valid && (count + outstanding) < DEPTH.
//   Accept (valid&&ready): pc <= pc + PC_STEP (mod 2^XLEN, wraps silently), outstanding++.
//  Response in RUN: push {rsp_pc, data}; rsp_pc += PC_STEP; outstanding--. Credit check guarantees no overflow.
//  Response in DRAIN (or same cycle as redirect): discarded, drop_cnt--/outstanding--.
//  Redirect (priority over everything): pc<=redirect_pc, rsp_pc<=redirect_pc, queue cleared,
//   drop_cnt<=outstanding - (rsp this cycle), no push, no pop.
//  Decode: id_valid = !empty && !redirect_valid (combinational gate); id_pc/id_instr = head (registered data).
//   Pop on id_valid&&id_ready. Push and pop same cycle allowed at any occupancy; count unchanged.
//  Latency: request accepted cycle N, response cycle M>=N+1, visible on id_* cycle M+1.
//  Empty: id_valid=0, id_* hold last head values. Full (count+outstanding==DEPTH): no new request.
//  Pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] (cycles id_valid&&!id_ready) and
//   perf_redirect_cnt[31:0] (redirect_valid cycles); both reset to 0, wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset, ready=1, 1-cycle mem: first req addr 0x0 in cycle 2; then 0x4,0x8,...; id_pc 0x0 one cycle after rsp.
//  id_ready=0 for 10 cycles, DEPTH=4: exactly 4 requests issued, then req_valid=0; release -> pcs 0x0..0xC in order.
//  3 outstanding, redirect to 0x100: 3 later responses dropped, next id_pc=0x100, state DRAIN->RUN.
//  Redirect coincident with response and id_ready=1: response dropped, no pop, drop_cnt=outstanding-1.
//  redirect_pc=0xFFFF_FFFC: following request addr 0x0 (wrap).
//  FETCH_PERF_CNT_EN: 5 stall cycles, 2 redirects -> perf_stall_cnt=5, perf_redirect_cnt=2; rst_n=0 -> both 0.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Fetch front-end: PC generation, in-order instruction-memory requests and a prefetch queue toward decode.
// Optional FETCH_PERF_CNT_EN adds stall and redirect performance counters.
module fetch_queue_stage #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [ILEN-1:0] id_instr,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_redirect_cnt
`else
    output logic [ILEN-1:0] id_instr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [ILEN-1:0] q_instr [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_instr;

    logic            credit_ok;
    logic            req_fire;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic [CW-1:0]   out_after_rsp;
    logic [CW-1:0]   count_after_pop;
    logic [AW-1:0]   next_rd;
    logic [XLEN-1:0] head_pc_d;
    logic [ILEN-1:0] head_instr_d;

    // Queue slots plus in-flight requests never exceed DEPTH, so a response always has room.
    assign credit_ok       = ((CW+1)'(count) + (CW+1)'(outstanding)) < (CW+1)'(DEPTH);
    assign imem_req_valid  = (state == RUN) && !redirect_valid && credit_ok;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign rsp_take        = imem_rsp_valid && (outstanding != '0);
    assign push            = (state == RUN) && !redirect_valid && rsp_take;
    assign id_valid        = (count != '0) && !redirect_valid;
    assign pop             = id_valid && id_ready;
    assign out_after_rsp   = outstanding - CW'(rsp_take);
    assign count_after_pop = count - CW'(pop);
    assign next_rd         = rd_ptr + AW'(pop);

    assign imem_req_addr = pc;
    assign id_pc         = head_pc;
    assign id_instr      = head_instr;

    // The head register mirrors whatever entry sits at the queue head after this cycle's push/pop.
    always_comb begin
        head_pc_d    = head_pc;
        head_instr_d = head_instr;
        if (push && (count_after_pop == '0)) begin
            head_pc_d    = rsp_pc;
            head_instr_d = imem_rsp_data;
        end else if (count_after_pop != '0) begin
            head_pc_d    = q_pc[next_rd];
            head_instr_d = q_instr[next_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= rsp_pc;
            q_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            head_pc     <= '0;
            head_instr  <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight now belongs to the old path and must be absorbed.
            pc          <= redirect_pc;
            rsp_pc      <= redirect_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= out_after_rsp;
            drop_cnt    <= out_after_rsp;
            state       <= (out_after_rsp != '0) ? DRAIN : RUN;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                DRAIN: begin
                    if (rsp_take) begin
                        drop_cnt <= drop_cnt - CW'(1);
                        if (drop_cnt == CW'(1)) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= state;
            endcase
            if (req_fire) begin
                pc <= pc + XLEN'(PC_STEP);
            end
            if (push) begin
                rsp_pc <= rsp_pc + XLEN'(PC_STEP);
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr      <= next_rd;
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            head_pc     <= head_pc_d;
            head_instr  <= head_instr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (id_valid && !id_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: directed scenarios plus randomized traffic,
// all checked each cycle against a queue-based behavioural model.
module tb_fetch_queue_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    fetch_queue_stage #(
        .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_pc(id_pc),
`ifdef FETCH_PERF_CNT_EN
        .id_instr(id_instr),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
`else
        .id_instr(id_instr)
`endif
    );

    always #5 clk = ~clk;

    // Model: fetch PC, requests in flight (with a stale flag) and the buffered {pc,instr} list.
    bit          model_on = 1'b0;
    bit          booted   = 1'b0;
    logic [31:0] m_pc     = '0;
    logic [31:0] held_pc  = '0;
    logic [31:0] held_instr = '0;
    logic [31:0] if_addr[$];
    bit          if_stale[$];
    logic [31:0] b_pc[$];
    logic [31:0] b_instr[$];
    int          m_stall  = 0;
    int          m_redir  = 0;
    bit          m_fire, m_pop, m_st;
    logic [31:0] m_a;

    function automatic bit expReqValid();
        int stale = 0;
        foreach (if_stale[i]) if (if_stale[i]) stale++;
        return booted && (stale == 0) && !redirect_valid && ((b_pc.size() + if_addr.size()) < DEPTH);
    endfunction

    function automatic bit expIdValid();
        return (b_pc.size() != 0) && !redirect_valid;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_on   = 1'b1;
            booted     = 1'b0;
            m_pc       = '0;
            held_pc    = '0;
            held_instr = '0;
            if_addr.delete();
            if_stale.delete();
            b_pc.delete();
            b_instr.delete();
            m_stall    = 0;
            m_redir    = 0;
        end else if (model_on) begin
            m_fire = expReqValid() && imem_req_ready;
            m_pop  = expIdValid() && id_ready;
            if (expIdValid() && !id_ready) m_stall++;
            if (redirect_valid) m_redir++;
            if (m_pop) begin
                void'(b_pc.pop_front());
                void'(b_instr.pop_front());
            end
            if (imem_rsp_valid && (if_addr.size() != 0)) begin
                m_a  = if_addr.pop_front();
                m_st = if_stale.pop_front();
                if (!m_st && !redirect_valid) begin
                    b_pc.push_back(m_a);
                    b_instr.push_back(imem_rsp_data);
                end
            end
            if (m_fire) begin
                if_addr.push_back(m_pc);
                if_stale.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
            if (redirect_valid) begin
                b_pc.delete();
                b_instr.delete();
                foreach (if_stale[i]) if_stale[i] = 1'b1;
                m_pc = redirect_pc;
            end
            booted = 1'b1;
            if (b_pc.size() != 0) begin
                held_pc    = b_pc[0];
                held_instr = b_instr[0];
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("req_valid", {31'b0, imem_req_valid}, {31'b0, expReqValid()});
            checkOutput("req_addr", imem_req_addr, m_pc);
            checkOutput("id_valid", {31'b0, id_valid}, {31'b0, expIdValid()});
            checkOutput("id_pc", id_pc, (b_pc.size() != 0) ? b_pc[0] : held_pc);
            checkOutput("id_instr", id_instr, (b_instr.size() != 0) ? b_instr[0] : held_instr);
        end
    end

    // Drives one cycle of inputs just after the edge, then returns at the sampling edge.
    task automatic applyStimulus(input bit rst, input bit rdv, input logic [31:0] rpc,
                                 input bit rq, input bit idr, input bit rsp_en);
        @(posedge clk);
        #1;
        rst_n          = rst;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        imem_req_ready = rq;
        id_ready       = idr;
        imem_rsp_valid = rst && rsp_en && (if_addr.size() != 0);
        imem_rsp_data  = $urandom;
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] d0;
    int          issued, got;
    bit          found;
    bit          r_rst, r_rdv, r_rq, r_idr, r_rsp;
    logic [31:0] r_pc;

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0;

        // Boot and first fetch with a one-cycle memory.
        doReset();
        checkOutput("reset_id_pc", id_pc, 32'h0);
        checkOutput("reset_id_valid", {31'b0, id_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("boot_no_req", {31'b0, imem_req_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        checkOutput("first_req_addr", imem_req_addr, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("second_req_addr", imem_req_addr, 32'h4);
        d0 = imem_rsp_data;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("first_id_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("first_id_pc", id_pc, 32'h0);
        checkOutput("first_id_instr", id_instr, d0);

        // Decode stalled: the credit limit caps issue at DEPTH requests.
        doReset();
        issued = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            if (imem_req_valid && imem_req_ready) issued++;
        end
        checkOutput("full_issue_count", issued, 32'd4);
        checkOutput("full_req_valid", {31'b0, imem_req_valid}, 32'h0);
        got = 0;
        for (int i = 0; i < 20 && got < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            if (id_valid && id_ready) begin
                checkOutput($sformatf("release_pc%0d", got), id_pc, 32'(got * 4));
                got++;
            end
        end
        checkOutput("release_pops", got, 32'd4);

        // Three requests in flight, then redirect to 0x100.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("drain_req_valid", {31'b0, imem_req_valid}, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (id_valid && id_ready) begin
                checkOutput("redirect_first_pc", id_pc, 32'h100);
                found = 1'b1;
            end
        end
        checkOutput("redirect_found", {31'b0, found}, 32'h1);

        // Redirect coincident with a response while decode is ready.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        checkOutput("coincident_id_valid", {31'b0, id_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("after_redirect_id_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("after_redirect_draining", {31'b0, imem_req_valid}, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (id_valid && id_ready) begin
                checkOutput("coincident_first_pc", id_pc, 32'h200);
                found = 1'b1;
            end
        end
        checkOutput("coincident_found", {31'b0, found}, 32'h1);

        // PC wrap at the top of the address space.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("wrap_req_valid", {31'b0, imem_req_valid}, 32'h1);
        checkOutput("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("wrap_addr1", imem_req_addr, 32'h0);

        // Randomized traffic with occasional redirects and resets.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 299) != 0);
            r_rdv = r_rst && ($urandom_range(0, 19) == 0);
            r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                                : ($urandom & 32'hFFFF_FFFC);
            r_rq  = ($urandom_range(0, 3) != 0);
            r_idr = ($urandom_range(0, 2) != 0);
            r_rsp = ($urandom_range(0, 4) < 3);
            applyStimulus(r_rst, r_rdv, r_pc, r_rq, r_idr, r_rsp);
        end

`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_stall", perf_stall_cnt, 32'(m_stall));
        checkOutput("perf_redirect", perf_redirect_cnt, 32'(m_redir));
        doReset();
        checkOutput("perf_stall_reset", perf_stall_cnt, 32'h0);
        checkOutput("perf_redirect_reset", perf_redirect_cnt, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
